lisp_mem_arbiter: RTL and testbench

- Parametrised successor to the single-port processor memory.
- Arbitrates NUM_PORTS requesters (e.g. instruction fetch, data, DMA) onto one tagged-word RAM plus a hardware-register window, using round-robin priority.
- Each requester uses a valid/ready handshake with a one-pulse response.
- Register accesses may stall via an acknowledge, bounded by a timeout that flags an error.

---
 rtl/lisp_mem_arbiter_if.sv | 30 +++
 rtl/lisp_mem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_lisp_mem_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lisp_mem_arbiter_if.sv
// Requester-side bus of lisp_mem_arbiter: NUM_PORTS valid/ready request channels plus a shared response.
// Latency: none, wiring only.
// Backpressure: each port holds req_valid and its payload until req_ready is seen high for that port.
// Ports (master = requesters, slave = arbiter):
//   req_valid/req_ready/req_write [NUM_PORTS], req_addr [NUM_PORTS*ADDR_WIDTH], req_wdata [NUM_PORTS*WORD_SIZE]
//   resp_valid [NUM_PORTS] one-cycle pulse, resp_data [WORD_SIZE], resp_error
interface lisp_mem_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_SIZE  = 20
);
  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS-1:0]            req_ready;
  logic [NUM_PORTS-1:0]            req_write;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS*WORD_SIZE-1:0]  req_wdata;
  logic [NUM_PORTS-1:0]            resp_valid;
  logic [WORD_SIZE-1:0]            resp_data;
  logic                            resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_data, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_data, resp_error
  );
endinterface

// File: rtl/lisp_mem_arbiter.sv
// Round-robin arbiter of NUM_PORTS requesters onto one tagged-word RAM plus a hardware-register window.
// Latency: RAM / out-of-range access responds 1 cycle after grant; register access responds 1 cycle after ack or timeout.
// Backpressure: one grant per cycle in IDLE only; all req_ready low while a register access is outstanding.
// Ports: clk, reset (async, active high); bus (lisp_mem_arbiter_if.slave) carries requests and responses;
//   register_index/read/write/write_value out and register_read_value/ack in form the register window.
// RAM contents are not initialised by this block; software loads them through the request ports.
module lisp_mem_arbiter #(
  parameter int                    MEM_SIZE       = 32640,
  parameter int                    WORD_SIZE      = 20,
  parameter int                    ADDR_WIDTH     = 16,
  parameter int                    NUM_PORTS      = 2,
  parameter logic [ADDR_WIDTH-1:0] REG_BASE       = 16'hFF80,
  parameter int                    REG_INDEX_BITS = 7,
  parameter int                    REG_TIMEOUT    = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  lisp_mem_arbiter_if.slave         bus,
  output logic [REG_INDEX_BITS-1:0] register_index,
  output logic                      register_read,
  output logic                      register_write,
  output logic [15:0]               register_write_value,
  input  logic [15:0]               register_read_value,
  input  logic                      register_ack
);

  localparam int PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int MEM_AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam int CNT_W  = $clog2(REG_TIMEOUT + 1);
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE);
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(REG_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REG_WAIT,
    S_RESP
  } state_t;

  state_t               state;
  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     port_q;
  logic                 reg_wr_q;
  logic [CNT_W-1:0]     tmo_cnt;

  logic [NUM_PORTS-1:0] resp_vld_q;
  logic                 resp_err_q;
  logic [WORD_SIZE-1:0] resp_data_q;
  logic                 sel_mem;
  logic [WORD_SIZE-1:0] mem_rdata;

  logic [WORD_SIZE-1:0] ram [MEM_SIZE];

  // Grant selection and the granted request's payload
  logic                  gnt_any;
  logic [PTR_W-1:0]      gnt_idx;
  logic [PTR_W-1:0]      cand;
  logic [PTR_W-1:0]      ptr_next;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [WORD_SIZE-1:0]  g_wdata;
  logic                  g_write;
  logic                  g_is_reg;
  logic                  g_is_mem;
  logic [MEM_AW-1:0]     mem_idx;
  logic                  mem_we;
  logic                  mem_re;

  // Scan from the pointer downward in reverse so the nearest valid port (smallest offset) wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (state == S_IDLE && !reset) begin
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
        cand = PTR_W'((int'(ptr) + k) % NUM_PORTS);
        if (bus.req_valid[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (gnt_any) bus.req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    g_addr  = '0;
    g_wdata = '0;
    g_write = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt_idx == PTR_W'(p)) begin
        g_addr  = bus.req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        g_wdata = bus.req_wdata[p*WORD_SIZE +: WORD_SIZE];
        g_write = bus.req_write[p];
      end
    end
  end

  assign ptr_next = PTR_W'((int'(gnt_idx) + 1) % NUM_PORTS);

  // The register window is matched first so it can never alias a RAM word.
  assign g_is_reg = (g_addr[ADDR_WIDTH-1:REG_INDEX_BITS] == REG_BASE[ADDR_WIDTH-1:REG_INDEX_BITS]);
  assign g_is_mem = !g_is_reg && ({1'b0, g_addr} < MEM_LIMIT);
  assign mem_idx  = g_addr[MEM_AW-1:0];
  assign mem_we   = gnt_any && g_is_mem && g_write;
  assign mem_re   = gnt_any && g_is_mem && !g_write;

  // RAM port kept free of reset so it maps onto block memory. A read in the cycle
  // after a write to the same word sees the committed data.
  always_ff @(posedge clk) begin
    if (mem_we) ram[mem_idx] <= g_wdata;
    if (mem_re) mem_rdata <= ram[mem_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= S_IDLE;
      ptr                  <= '0;
      port_q               <= '0;
      reg_wr_q             <= 1'b0;
      tmo_cnt              <= '0;
      resp_vld_q           <= '0;
      resp_err_q           <= 1'b0;
      resp_data_q          <= '0;
      sel_mem              <= 1'b0;
      register_index       <= '0;
      register_read        <= 1'b0;
      register_write       <= 1'b0;
      register_write_value <= '0;
    end else begin
      resp_vld_q <= '0;
      resp_err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (gnt_any) begin
            ptr <= ptr_next;
            if (g_is_reg) begin
              state                <= S_REG_WAIT;
              port_q               <= gnt_idx;
              reg_wr_q             <= g_write;
              tmo_cnt              <= '0;
              register_index       <= g_addr[REG_INDEX_BITS-1:0];
              register_write_value <= g_wdata[15:0];
              register_read        <= !g_write;
              register_write       <= g_write;
            end else begin
              // RAM reads take data from the RAM port; writes and out-of-range return zero.
              resp_vld_q  <= NUM_PORTS'(1) << gnt_idx;
              sel_mem     <= mem_re;
              resp_data_q <= '0;
            end
          end
        end
        S_REG_WAIT: begin
          if (register_ack) begin
            state          <= S_RESP;
            tmo_cnt        <= '0;
            register_read  <= 1'b0;
            register_write <= 1'b0;
            resp_vld_q     <= NUM_PORTS'(1) << port_q;
            sel_mem        <= 1'b0;
            resp_data_q    <= reg_wr_q ? '0 : {{(WORD_SIZE-16){1'b0}}, register_read_value};
          end else if (tmo_cnt == CNT_LAST) begin
            // Last allowed wait cycle without ack: abandon the access and flag it.
            state          <= S_RESP;
            tmo_cnt        <= '0;
            register_read  <= 1'b0;
            register_write <= 1'b0;
            resp_vld_q     <= NUM_PORTS'(1) << port_q;
            resp_err_q     <= 1'b1;
            sel_mem        <= 1'b0;
            resp_data_q    <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_RESP: begin
          // The response pulse registered on entry is visible this cycle; no grant here.
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.resp_valid = resp_vld_q;
  assign bus.resp_error = resp_err_q;
  assign bus.resp_data  = sel_mem ? mem_rdata : resp_data_q;

endmodule

// File: tb/tb_lisp_mem_arbiter.sv
// Bench for lisp_mem_arbiter: directed scenarios plus randomized traffic against a queue/array reference model.
// Latency: n/a. Backpressure: per-port request queues hold each request until it is accepted.
module tb_lisp_mem_arbiter;
  localparam int NP  = 2;
  localparam int AW  = 16;
  localparam int WS  = 20;
  localparam int RIB = 7;
  localparam int TMO = 15;
  localparam int MS  = 32640;

  logic           clk = 1'b0;
  logic           reset;
  logic [RIB-1:0] register_index;
  logic           register_read;
  logic           register_write;
  logic [15:0]    register_write_value;
  logic [15:0]    register_read_value;
  logic           register_ack;

  lisp_mem_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .WORD_SIZE(WS)) bus ();

  lisp_mem_arbiter #(
    .MEM_SIZE(MS), .WORD_SIZE(WS), .ADDR_WIDTH(AW), .NUM_PORTS(NP),
    .REG_BASE(16'hFF80), .REG_INDEX_BITS(RIB), .REG_TIMEOUT(TMO)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .bus                  (bus),
    .register_index       (register_index),
    .register_read        (register_read),
    .register_write       (register_write),
    .register_write_value (register_write_value),
    .register_read_value  (register_read_value),
    .register_ack         (register_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic w; logic [15:0] a; logic [19:0] d; } req_t;
  typedef struct packed { logic [3:0] port; logic [19:0] data; logic err; } rlog_t;

  req_t  pq [NP][$];
  rlog_t rlog[$];

  int errs = 0;
  int checks = 0;
  int resp_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- request drivers ----------------
  logic [NP-1:0] acc;
  initial begin
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    forever begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      @(posedge clk);
      if (reset) acc = '0;
      #1;
      for (int p = 0; p < NP; p++) begin
        if (acc[p]) void'(pq[p].pop_front());
        if (pq[p].size() > 0) begin
          bus.req_valid[p]          = 1'b1;
          bus.req_write[p]          = pq[p][0].w;
          bus.req_addr[p*AW +: AW]  = pq[p][0].a;
          bus.req_wdata[p*WS +: WS] = pq[p][0].d;
        end else begin
          bus.req_valid[p] = 1'b0;
        end
      end
    end
  end

  // ---------------- register responder ----------------
  int    ack_delay  = 1;
  bit    ack_random = 1'b0;
  logic [15:0] ack_val = 16'h0;
  int    r_cnt = 0;
  int    r_dly = 0;
  initial begin
    register_ack        = 1'b0;
    register_read_value = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      register_read_value = 16'($urandom);
      if (register_read || register_write) begin
        if (r_cnt == 0) r_dly = ack_random ? int'($urandom_range(1, 18)) : ack_delay;
        r_cnt++;
        register_ack = (r_cnt == r_dly);
        if (register_ack && !ack_random) register_read_value = ack_val;
      end else begin
        r_cnt        = 0;
        register_ack = 1'b0;
      end
    end
  end

  // ---------------- reference model and compare ----------------
  logic [19:0] m_ram [int];
  int          m_ptr = 0;
  int          m_phase = 0;   // 0 arbitration open, 1 register access pending, 2 register response cycle
  int          m_cnt = 0;
  int          m_port = 0;
  logic        m_w = 1'b0;
  logic [15:0] m_idx = 16'h0;
  logic [15:0] m_wv = 16'h0;
  bit          pend_vld = 1'b0;
  int          pend_port = 0;
  logic [19:0] pend_data = 20'h0;
  logic        pend_err = 1'b0;
  bit          pend_known = 1'b0;
  bit          have_last = 1'b0;
  logic [19:0] last_data = 20'h0;
  int          run = 0;
  int          last_run = 0;
  logic [RIB-1:0] last_idx = '0;

  initial begin
    int          g;
    int          ap;
    logic [15:0] a;
    logic [19:0] d;
    logic        w;
    logic [NP-1:0] exp_rv;
    logic [NP-1:0] exp_rdy;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 0);
        chk("rst_resp_error", 32'(bus.resp_error), 0);
        chk("rst_strobes", {30'b0, register_read, register_write}, 0);
        chk("rst_reg_index", 32'(register_index), 0);
        chk("rst_reg_wval", 32'(register_write_value), 0);
        m_ptr = 0; m_phase = 0; pend_vld = 0; run = 0; have_last = 0;
      end else begin
        exp_rv = pend_vld ? (NP'(1) << pend_port) : '0;
        chk("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
        chk("resp_error", 32'(bus.resp_error), pend_vld ? 32'(pend_err) : 32'(0));
        if (pend_vld && pend_known) chk("resp_data", 32'(bus.resp_data), 32'(pend_data));
        if (!pend_vld && have_last) chk("resp_data_hold", 32'(bus.resp_data), 32'(last_data));
        if (bus.resp_valid != '0) begin
          ap = 0;
          for (int p = NP - 1; p >= 0; p--) if (bus.resp_valid[p]) ap = p;
          rlog.push_back('{4'(ap), bus.resp_data, bus.resp_error});
          resp_cnt++;
          have_last = 1'b1;
          last_data = bus.resp_data;
        end
        if (register_read || register_write) begin
          run++;
          last_idx = register_index;
        end else if (run > 0) begin
          last_run = run;
          run = 0;
        end
        if (m_phase == 1) begin
          chk("reg_read", 32'(register_read), 32'(!m_w));
          chk("reg_write", 32'(register_write), 32'(m_w));
          chk("reg_index", 32'(register_index), 32'(m_idx));
          chk("reg_wval", 32'(register_write_value), 32'(m_wv));
        end else begin
          chk("reg_strobes_idle", {30'b0, register_read, register_write}, 0);
        end
        g = -1;
        if (m_phase == 0)
          for (int k = 0; k < NP; k++)
            if (g < 0 && bus.req_valid[(m_ptr + k) % NP]) g = (m_ptr + k) % NP;
        exp_rdy = (g >= 0) ? (NP'(1) << g) : '0;
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));

        pend_vld = 0;
        case (m_phase)
          0: if (g >= 0) begin
            a = bus.req_addr[g*AW +: AW];
            d = bus.req_wdata[g*WS +: WS];
            w = bus.req_write[g];
            m_ptr = (g + 1) % NP;
            if (a >= 16'hFF80) begin
              m_phase = 1; m_cnt = 0; m_port = g; m_w = w;
              m_idx = a - 16'hFF80; m_wv = d[15:0];
            end else begin
              pend_vld = 1; pend_port = g; pend_err = 0; pend_known = 1; pend_data = 20'h0;
              if (int'(a) < MS) begin
                if (w) m_ram[int'(a)] = d;
                else if (m_ram.exists(int'(a))) pend_data = m_ram[int'(a)];
                else pend_known = 0;
              end
            end
          end
          1: begin
            if (register_ack) begin
              pend_vld = 1; pend_port = m_port; pend_err = 0; pend_known = 1;
              pend_data = m_w ? 20'h0 : {4'h0, register_read_value};
              m_phase = 2;
            end else begin
              m_cnt++;
              if (m_cnt == TMO) begin
                pend_vld = 1; pend_port = m_port; pend_err = 1; pend_known = 1; pend_data = 20'h0;
                m_phase = 2;
              end
            end
          end
          default: m_phase = 0;
        endcase
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_resp(input int n, input string nm);
    int target;
    target = resp_cnt + n;
    for (int i = 0; i < 300 && resp_cnt < target; i++) @(posedge clk);
    chk({nm, "_resp_count"}, 32'(resp_cnt), 32'(target));
  endtask

  task automatic wait_strobe(input string nm);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #2;
      if (register_read || register_write) break;
    end
    chk({nm, "_strobe_seen"}, 32'(register_read | register_write), 1);
  endtask

  function automatic logic [15:0] rnd_addr();
    case ($urandom_range(0, 9))
      0: return 16'h7F7F;
      1: return 16'h7F80;
      2: return 16'h8000 | 16'($urandom_range(0, 15));
      3: return 16'hFF80 | 16'($urandom_range(0, 127));
      default: return 16'($urandom_range(0, 15));
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);

    // Write then read back the same word from port 0.
    pq[0].push_back('{1'b1, 16'h0010, 20'h5ABCD});
    pq[0].push_back('{1'b0, 16'h0010, 20'h0});
    wait_resp(2, "t1");
    chk("t1_read_data", 32'(rlog[rlog.size()-1].data), 32'h5ABCD);
    chk("t1_read_port", 32'(rlog[rlog.size()-1].port), 0);

    // Preload words 1 and 2 from port 1, then both ports contend.
    pq[1].push_back('{1'b1, 16'h0001, 20'h00011});
    pq[1].push_back('{1'b1, 16'h0002, 20'h00022});
    wait_resp(2, "t2_pre");
    rlog.delete();
    for (int i = 0; i < 4; i++) begin
      pq[0].push_back('{1'b0, 16'h0001, 20'h0});
      pq[1].push_back('{1'b0, 16'h0002, 20'h0});
    end
    wait_resp(8, "t2");
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_port_%0d", i), 32'(rlog[i].port), 32'(i % 2));
      chk($sformatf("t2_data_%0d", i), 32'(rlog[i].data), (i % 2) ? 32'h22 : 32'h11);
    end

    // Register read acknowledged on the third strobe cycle; port 0 stalls meanwhile.
    ack_random = 1'b0; ack_delay = 3; ack_val = 16'hBEEF;
    rlog.delete();
    pq[1].push_back('{1'b0, 16'hFF85, 20'h0});
    wait_strobe("t3");
    pq[0].push_back('{1'b0, 16'h0001, 20'h0});
    wait_resp(2, "t3");
    chk("t3_reg_port", 32'(rlog[0].port), 1);
    chk("t3_reg_data", 32'(rlog[0].data), 32'h0BEEF);
    chk("t3_reg_err", 32'(rlog[0].err), 0);
    chk("t3_reg_index", 32'(last_idx), 5);
    chk("t3_strobe_cycles", 32'(last_run), 3);
    chk("t3_stalled_port", 32'(rlog[1].port), 0);

    // Register write never acknowledged: timeout.
    ack_delay = -1;
    rlog.delete();
    pq[0].push_back('{1'b1, 16'hFF80, 20'h01234});
    wait_resp(1, "t4");
    chk("t4_port", 32'(rlog[0].port), 0);
    chk("t4_data", 32'(rlog[0].data), 0);
    chk("t4_err", 32'(rlog[0].err), 1);
    chk("t4_strobe_cycles", 32'(last_run), 15);

    // Out-of-range accesses; a write to 0x8010 must not alias word 0x0010.
    rlog.delete();
    pq[0].push_back('{1'b1, 16'h7FA0, 20'h12345});
    pq[0].push_back('{1'b0, 16'h7FA0, 20'h0});
    pq[0].push_back('{1'b1, 16'h8010, 20'h3C3C3});
    pq[0].push_back('{1'b0, 16'h0010, 20'h0});
    wait_resp(4, "t5");
    chk("t5_oor_data", 32'(rlog[1].data), 0);
    chk("t5_oor_err", 32'(rlog[1].err), 0);
    chk("t5_alias_data", 32'(rlog[3].data), 32'h5ABCD);

    // Reset during a register wait.
    pq[1].push_back('{1'b0, 16'hFF81, 20'h0});
    wait_strobe("t6");
    c0 = resp_cnt;
    reset = 1'b1;
    #1;
    chk("t6_async_read_drop", 32'(register_read), 0);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    chk("t6_no_resp", 32'(resp_cnt), 32'(c0));
    rlog.delete();
    pq[0].push_back('{1'b0, 16'h0001, 20'h0});
    pq[1].push_back('{1'b0, 16'h0002, 20'h0});
    wait_resp(2, "t6");
    chk("t6_first_port", 32'(rlog[0].port), 0);
    chk("t6_first_data", 32'(rlog[0].data), 32'h11);

    // Randomized traffic.
    ack_random = 1'b1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(posedge clk);
      #3;
      for (int p = 0; p < NP; p++)
        if (pq[p].size() < 2 && $urandom_range(0, 2) != 0)
          pq[p].push_back('{1'($urandom), rnd_addr(), 20'($urandom)});
    end
    for (int i = 0; i < 2000 && (pq[0].size() > 0 || pq[1].size() > 0); i++) @(posedge clk);
    chk("rand_drained", 32'(pq[0].size() + pq[1].size()), 0);
    repeat (25) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
